// File: rtl/mod_cnt_pkg.sv
// Shared constants for the modulo up/down counter: default parameter values
// and the encoding of the direction input.
package mod_cnt_pkg;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_MODULUS  = 16;
  localparam int DEF_PRESCALE = 1;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/cnt_prescaler.sv
// Enabled-cycle prescaler: raises tick on every PRESCALE-th enabled cycle.
// restart returns the phase to zero and suppresses the tick of that cycle.
module cnt_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tick
);

  // With PRESCALE=1 the phase register is constant zero, so tick reduces to en.
  localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;
  logic          at_last;

  assign at_last = (cnt_q == LAST);
  assign tick    = en && at_last && !restart;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = at_last ? '0 : cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-MODULUS up/down counter with prescaler, load, clear and terminal-count pulse.
// Define MOD_UPDOWN_COUNTER_SAT_EN to saturate at the boundaries instead of wrapping.
module mod_updown_counter
  import mod_cnt_pkg::*;
#(
  parameter int     WIDTH    = DEF_WIDTH,
  parameter longint MODULUS  = DEF_MODULUS,
  parameter int     PRESCALE = DEF_PRESCALE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("mod_updown_counter: WIDTH=%0d outside 1..32", WIDTH);
  end
  if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
    $error("mod_updown_counter: MODULUS=%0d outside 2..2**WIDTH", MODULUS);
  end
  if (PRESCALE < 1 || PRESCALE > 256) begin : g_bad_prescale
    $error("mod_updown_counter: PRESCALE=%0d outside 1..256", PRESCALE);
  end

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             tc_q;
  logic             tc_d;
  logic             tick;
  logic             at_bound;

  cnt_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .restart(clr | load),
    .tick   (tick)
  );

  // A boundary is the value from which the next step in the current direction wraps.
  assign at_bound = (up == DIR_UP) ? (q_q == MAX_Q) : (q_q == '0);

  always_comb begin
    q_d  = q_q;
    tc_d = 1'b0;
    if (clr) begin
      q_d = '0;
    end else if (load) begin
      q_d = (load_val > MAX_Q) ? MAX_Q : load_val;
    end else if (tick) begin
      tc_d = at_bound;
`ifdef MOD_UPDOWN_COUNTER_SAT_EN
      if (!at_bound) begin
        q_d = (up == DIR_UP) ? q_q + ONE : q_q - ONE;
      end
`else
      if (up == DIR_UP) begin
        q_d = at_bound ? '0 : q_q + ONE;
      end else begin
        q_d = at_bound ? MAX_Q : q_q - ONE;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q  <= '0;
      tc_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      tc_q <= tc_d;
    end
  end

  assign q  = q_q;
  assign tc = tc_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: two instances (PRESCALE 1 and 3, MODULUS 10)
// share stimulus and are compared every cycle against an arithmetic model.
module tb_mod_updown_counter;

`ifdef MOD_UPDOWN_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    int q;
    int ps;
    bit tc;
  } mstate_t;

  // clock / reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       en;
  logic       up;
  logic       load;
  logic       clr;
  logic [3:0] load_val;
  logic [3:0] a_q;
  logic       a_tc;
  logic [3:0] b_q;
  logic       b_tc;

  int n_chk = 0;
  int n_err = 0;
  bit cmp_on = 1'b0;

  mstate_t ma = '{q: 0, ps: 0, tc: 1'b0};
  mstate_t mb = '{q: 0, ps: 0, tc: 1'b0};

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val), .clr(clr), .q(a_q), .tc(a_tc)
  );

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) dut_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val), .clr(clr), .q(b_q), .tc(b_tc)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: one edge of a modulo-md counter with an ps_n-cycle prescaler.
  function automatic mstate_t model_next(mstate_t s, int md, int ps_n,
                                         logic c, logic l, logic e, logic u,
                                         logic [3:0] lv);
    mstate_t n;
    bit bound;
    n = s;
    n.tc = 1'b0;
    if (c) begin
      n.q  = 0;
      n.ps = 0;
    end else if (l) begin
      n.q  = (int'(lv) > md - 1) ? md - 1 : int'(lv);
      n.ps = 0;
    end else if (e) begin
      if (s.ps == ps_n - 1) begin
        n.ps  = 0;
        bound = u ? (s.q == md - 1) : (s.q == 0);
        n.tc  = bound;
        if (SAT && bound) n.q = s.q;
        else n.q = u ? (s.q + 1) % md : (s.q + md - 1) % md;
      end else begin
        n.ps = s.ps + 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ma <= '{q: 0, ps: 0, tc: 1'b0};
      mb <= '{q: 0, ps: 0, tc: 1'b0};
    end else begin
      ma <= model_next(ma, 10, 1, clr, load, en, up, load_val);
      mb <= model_next(mb, 10, 3, clr, load, en, up, load_val);
    end
  end

  // scoreboard compare, once per cycle away from the active edge
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("a_q",  a_q,  ma.q);
      chk("a_tc", a_tc, ma.tc);
      chk("b_q",  b_q,  mb.q);
      chk("b_tc", b_tc, mb.tc);
    end
  end

  task automatic drive_idle();
    en = 1'b0; up = 1'b1; load = 1'b0; clr = 1'b0; load_val = 4'd0;
  endtask

  initial begin
    int exp_q;
    int exp_tc;
    int r;
    rst = 1'b0;
    drive_idle();
    repeat (3) @(negedge clk);
    chk("reset_q", a_q, 0);
    chk("reset_tc", a_tc, 0);
    cmp_on = 1'b1;

    // count up from reset, PRESCALE 1 and 3
    rst = 1'b1; en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (SAT) begin
        exp_q  = (k > 9) ? 9 : k;
        exp_tc = (k >= 10) ? 1 : 0;
      end else begin
        exp_q  = k % 10;
        exp_tc = (k == 10) ? 1 : 0;
      end
      chk("up_seq_q", a_q, exp_q);
      chk("up_seq_tc", a_tc, exp_tc);
      chk("up_pre3_q", b_q, k / 3);
    end

    // count down after clear
    clr = 1'b1; up = 1'b0;
    @(negedge clk);
    chk("clr_q", a_q, 0);
    chk("clr_tc", a_tc, 0);
    clr = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("down_seq_q", a_q, SAT ? 0 : 10 - k);
      chk("down_seq_tc", a_tc, (SAT || k == 1) ? 1 : 0);
    end
    chk("down_pre3_q", b_q, SAT ? 0 : 9);
    chk("down_pre3_tc", b_tc, 1);

    // enable gap in the middle of a prescale period
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; en = 1'b1; up = 1'b1;
    repeat (2) @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    chk("gap_hold_q", b_q, 0);
    en = 1'b1;
    @(negedge clk);
    chk("gap_step_q", b_q, 1);
    chk("gap_step_tc", b_tc, 0);

    // load clamping and priorities
    load = 1'b1; load_val = 4'd12;
    @(negedge clk);
    chk("load_clamp_a", a_q, 9);
    chk("load_clamp_b", b_q, 9);
    clr = 1'b1; load_val = 4'd5;
    @(negedge clk);
    chk("load_clr_q", a_q, 0);
    clr = 1'b0; en = 1'b0; load_val = 4'd7;
    @(negedge clk);
    chk("load_noen_q", a_q, 7);
    load = 1'b0;
    @(negedge clk);
    chk("hold_noen_q", a_q, 7);
    chk("hold_noen_tc", a_tc, 0);

    // asynchronous reset between edges
    #2 rst = 1'b0;
    #1;
    chk("async_rst_q", a_q, 0);
    chk("async_rst_tc", a_tc, 0);
    @(negedge clk);
    rst = 1'b1; en = 1'b1; up = 1'b1;
    @(negedge clk);
    chk("post_rst_q", a_q, 1);

    // randomized traffic, checked by the scoreboard process
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      r        = $urandom_range(0, 99);
      clr      = (r < 2);
      load     = (r >= 2 && r < 6);
      en       = ($urandom_range(0, 3) != 0);
      up       = (((i / 40) % 2) == 0) ^ ($urandom_range(0, 9) == 0);
      load_val = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 249) == 0) begin
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
    end
    @(negedge clk);
    cmp_on = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mod_updown_counter.md
MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits; legal range 1..32.
REQ-002 Parameter MODULUS, default 16, count range 0..MODULUS-1; legal range 2..2**WIDTH.
REQ-003 Parameter PRESCALE, default 1, enabled cycles per count step; legal range 1..256.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge only.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 en  in  1  count enable; prescaler and counter SHALL hold while low.
REQ-007 up  in  1  direction; 1 counts up, 0 counts down.
REQ-008 load  in  1  synchronous load strobe.
REQ-009 load_val  in  WIDTH  value written on load.
REQ-010 clr  in  1  synchronous clear.
REQ-011 q  out  WIDTH  registered count.
REQ-012 tc  out  1  registered terminal-count pulse, one cycle wide.

Function
REQ-013 Priority SHALL be clr > load > count step, evaluated on each rising clk edge.
REQ-014 clr SHALL set q=0, prescaler=0 and tc=0 on the next edge, regardless of en.
REQ-015 load SHALL set q=min(load_val, MODULUS-1), prescaler=0 and tc=0 on the next edge, regardless of en.
REQ-016 Prescaler SHALL count enabled cycles from 0 to PRESCALE-1; tick = en and (prescaler==PRESCALE-1); on tick it SHALL return to 0.
REQ-017 With PRESCALE=1, tick SHALL equal en (one step per enabled cycle).
REQ-018 On tick with up=1: q SHALL increment; q==MODULUS-1 SHALL wrap to 0.
REQ-019 On tick with up=0: q SHALL decrement; q==0 SHALL wrap to MODULUS-1.
REQ-020 tc SHALL be 1 in the cycle after any tick taken at a boundary (q==MODULUS-1 up, q==0 down); otherwise 0.
REQ-021 Count latency: the new q SHALL be visible after the same edge that samples the tick; no combinational path from inputs to q or tc.
REQ-022 A change of up SHALL take effect at the next tick; prescaler phase SHALL be preserved.
REQ-023 While en=0 and no clr/load, q, prescaler SHALL hold and tc SHALL be 0.
REQ-024 Arithmetic SHALL be modulo MODULUS, never modulo 2**WIDTH; q SHALL never exceed MODULUS-1.

Reset
REQ-025 rst low SHALL immediately force q=0, tc=0, prescaler=0, independent of clk.
REQ-026 Reset release SHALL be synchronous-safe: first step no earlier than the first edge after rst rises; a reset asserted mid-prescale SHALL discard the partial prescale count.

Configuration
REQ-027 Macro MOD_UPDOWN_COUNTER_SAT_EN SHALL select saturating mode when defined.
REQ-028 Defined: a boundary tick SHALL hold q (MODULUS-1 up, 0 down) and still pulse tc per REQ-020.
REQ-029 Undefined: wrap-around per REQ-018/REQ-019; no saturating logic SHALL be present.

Structure
REQ-030 Package mod_cnt_pkg SHALL hold default WIDTH/MODULUS/PRESCALE constants and direction constants DIR_UP=1, DIR_DOWN=0.
REQ-031 Sub-module cnt_prescaler SHALL implement REQ-016/REQ-017 (inputs clk, rst, en, restart; output tick); restart driven by clr or load.
REQ-032 Parameter legality (REQ-001..REQ-003) SHALL be checked at elaboration with an error on violation.

Verification
REQ-033 WIDTH=4, MODULUS=10, PRESCALE=1, up=1, en=1 from reset -> q 0..9, 0; tc=1 exactly in the cycle q first reads 0 after 9.
REQ-034 Same, up=0 from reset -> q 0, 9, 8, ...; tc=1 in the cycle q reads 9.
REQ-035 PRESCALE=3, en=1, up=1 -> q steps every 3rd cycle; en low for 2 cycles mid-prescale -> step delayed exactly 2 cycles.
REQ-036 load=1, load_val=12, MODULUS=10 -> q=9; load and clr same cycle -> q=0; load with en=0 -> q loaded.
REQ-037 rst low asynchronously between edges with q=7 -> q=0, tc=0 before next edge; counting resumes from 0 after release.
REQ-038 MOD_UPDOWN_COUNTER_SAT_EN defined, MODULUS=10, up=1 -> q holds at 9, tc pulses each further tick; up=0 at q=0 -> holds at 0.
